fifo_reader: RTL and testbench

FIFO_READER -- requirements
Module: fifo_reader

---
 rtl/fifo_pkg.sv | 19 +
 rtl/skid_buf2.sv | 69 ++++++
 rtl/fifo_reader.sv | 142 ++++++++++++++
 tb/tb_fifo_reader.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared types and constants for the FIFO-to-stream reader.
package fifo_pkg;

    localparam int BEAT_CNT_W = 16;
    // Frame position counter width; covers BURST_LEN up to 256.
    localparam int FRAME_W    = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2
    } state_t;

    // Delivered-beat counter step; wraps naturally at the counter width.
    function automatic logic [BEAT_CNT_W-1:0] beat_inc(input logic [BEAT_CNT_W-1:0] cnt);
        return cnt + BEAT_CNT_W'(1);
    endfunction

endpackage

// File: rtl/skid_buf2.sv
// Two-entry in-order buffer. entry0 is always the head, so the head output
// comes straight from a register and stays stable while nothing is popped.
module skid_buf2 #(
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] entry0_r;
    logic [WIDTH-1:0] entry1_r;
    logic [1:0]       count_r;
    logic             pop_s;
    logic             push_s;

    // Qualify requests: no pop from empty, no push into full unless a pop frees room.
    always_comb begin
        pop_s  = pop && (count_r != 2'd0);
        push_s = push && ((count_r != 2'd2) || pop_s);
    end

    // Storage and occupancy update.
    always_ff @(posedge clk) begin
        if (!rst) begin
            entry0_r <= '0;
            entry1_r <= '0;
            count_r  <= 2'd0;
        end else begin
            case ({push_s, pop_s})
                2'b10: begin
                    if (count_r == 2'd0) begin
                        entry0_r <= din;
                    end else begin
                        entry1_r <= din;
                    end
                    count_r <= count_r + 2'd1;
                end
                2'b01: begin
                    entry0_r <= entry1_r;
                    count_r  <= count_r - 2'd1;
                end
                2'b11: begin
                    if (count_r == 2'd1) begin
                        entry0_r <= din;
                    end else begin
                        entry0_r <= entry1_r;
                        entry1_r <= din;
                    end
                end
                default: begin
                    count_r <= count_r;
                end
            endcase
        end
    end

    assign full  = (count_r == 2'd2);
    assign empty = (count_r == 2'd0);
    assign head  = entry0_r;
    assign count = count_r;

endmodule

// File: rtl/fifo_reader.sv
// Reads words from a synchronous FIFO and presents them as a valid/ready
// stream with frame markers, a delivered-beat counter and a sticky underrun flag.
module fifo_reader
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int BURST_LEN  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rdata,
    input  logic                  fifo_error,
    output logic                  fifo_read_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic [15:0]           beat_cnt,
    output logic                  underrun,
    output logic [1:0]            state
);

    state_t                  state_r;
    logic                    inflight_r;
    logic [FRAME_W-1:0]      frame_cnt_r;
    logic [BEAT_CNT_W-1:0]   beat_cnt_r;
    logic                    underrun_r;

    logic                    buf_full_s;
    logic                    buf_empty_s;
    logic [1:0]              buf_count_s;
    logic [DATA_WIDTH:0]     buf_head_s;
    logic [DATA_WIDTH:0]     buf_din_s;
    logic                    xfer_s;
    logic [2:0]              occ_s;
    logic                    room_s;
    logic                    rd_en_s;
    logic                    capture_s;
    logic                    last_s;

    // Read gating: a pop in this cycle frees a slot, which keeps one beat per cycle.
    always_comb begin
        xfer_s    = !buf_empty_s && m_ready;
        occ_s     = {1'b0, buf_count_s} + {2'b00, inflight_r};
        room_s    = xfer_s || (occ_s < 3'd2);
        rd_en_s   = rst && (state_r != IDLE) && en && !fifo_empty && room_s;
        capture_s = inflight_r && !fifo_error;
        last_s    = (frame_cnt_r == FRAME_W'(BURST_LEN - 1));
        buf_din_s = {last_s, fifo_rdata};
    end

    skid_buf2 #(
        .WIDTH (DATA_WIDTH + 1)
    ) u_buf (
        .clk   (clk),
        .rst   (rst),
        .push  (capture_s),
        .din   (buf_din_s),
        .pop   (xfer_s),
        .full  (buf_full_s),
        .empty (buf_empty_s),
        .head  (buf_head_s),
        .count (buf_count_s)
    );

    // Control FSM, in-flight tracking and frame position (tagged at push time).
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r     <= IDLE;
            inflight_r  <= 1'b0;
            frame_cnt_r <= '0;
        end else begin
            inflight_r <= rd_en_s;
            if (capture_s) begin
                frame_cnt_r <= last_s ? '0 : frame_cnt_r + FRAME_W'(1);
            end else begin
                frame_cnt_r <= frame_cnt_r;
            end
            case (state_r)
                IDLE: begin
                    if (en && !fifo_empty) begin
                        state_r <= RUN;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    if (buf_full_s && !m_ready) begin
                        state_r <= STALL;
                    end else if ((!en || fifo_empty) && !inflight_r && buf_empty_s) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= RUN;
                    end
                end
                STALL: begin
                    if (m_ready) begin
                        state_r <= RUN;
                    end else begin
                        state_r <= STALL;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Total delivered beats, wrapping at the counter width.
    always_ff @(posedge clk) begin
        if (!rst) begin
            beat_cnt_r <= '0;
        end else if (xfer_s) begin
            beat_cnt_r <= beat_inc(beat_cnt_r);
        end else begin
            beat_cnt_r <= beat_cnt_r;
        end
    end

    // Sticky underrun: an errored capture is flagged and its word dropped.
    always_ff @(posedge clk) begin
        if (!rst) begin
            underrun_r <= 1'b0;
        end else if (inflight_r && fifo_error) begin
            underrun_r <= 1'b1;
        end else begin
            underrun_r <= underrun_r;
        end
    end

    assign fifo_read_en = rd_en_s;
    assign m_valid      = !buf_empty_s;
    assign m_data       = buf_head_s[DATA_WIDTH-1:0];
    assign m_last       = buf_head_s[DATA_WIDTH];
    assign beat_cnt     = beat_cnt_r;
    assign underrun     = underrun_r;
    assign state        = state_r;

endmodule

// File: tb/tb_fifo_reader.sv
// Self-checking bench for fifo_reader: FIFO model, scoreboard of expected
// beats, a table of streaming scenarios and hand-written corner sequences.
module tb_fifo_reader;

    localparam int DW = 8;
    localparam int BL = 4;

    logic          clk;
    logic          rst;
    logic          en;
    logic          fifo_empty;
    logic [DW-1:0] fifo_rdata;
    logic          fifo_error;
    logic          fifo_read_en;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic [15:0]   beat_cnt;
    logic          underrun;
    logic [1:0]    state;

    fifo_reader #(.DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .fifo_empty   (fifo_empty),
        .fifo_rdata   (fifo_rdata),
        .fifo_error   (fifo_error),
        .fifo_read_en (fifo_read_en),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .m_last       (m_last),
        .beat_cnt     (beat_cnt),
        .underrun     (underrun),
        .state        (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    typedef struct {
        int   n_words;
        int   stall_at;
        int   drop_after;
        int   err_word;
        bit   chk_timing;
        int   exp_beats;
        int   exp_reads;
        logic exp_underrun;
    } vec_t;

    exp_t          exp_q[$];
    vec_t          vecs[4];
    logic [DW-1:0] mem [0:255];
    int checks, errors;
    int n_reads, n_beats, exp_idx, err_idx, cyc;
    int first_rd, first_vld, first_beat, last_beat;
    int wr_ptr, rd_ptr;
    bit gen_mode;
    logic prev_hold, prev_last;
    logic [DW-1:0] prev_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One clock: observe at negedge, then advance the FIFO model after the edge.
    task automatic cycle();
        logic rd_now;
        exp_t e;
        @(negedge clk);
        cyc++;
        rd_now = fifo_read_en;
        if (rst) begin
            if (prev_hold) begin
                check("hold_valid", 32'(m_valid), 32'd1);
                check("hold_data", 32'(m_data), 32'(prev_data));
                check("hold_last", 32'(m_last), 32'(prev_last));
            end
            if (fifo_read_en) begin
                n_reads++;
                check("no_underflow", 32'(fifo_empty), 32'd0);
                if (first_rd < 0) first_rd = cyc;
            end
            if (m_valid && first_vld < 0) first_vld = cyc;
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: actual=%0h required=none", m_data);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_data", 32'(m_data), 32'(e.data));
                    check("beat_last", 32'(m_last), 32'(e.last));
                end
                n_beats++;
                if (first_beat < 0) first_beat = cyc;
                last_beat = cyc;
            end
            prev_hold = m_valid && !m_ready;
            prev_data = m_data;
            prev_last = m_last;
        end else begin
            prev_hold = 1'b0;
        end
        @(posedge clk);
        #1;
        fifo_error = 1'b0;
        if (rd_now === 1'b1) begin
            fifo_rdata = gen_mode ? DW'(rd_ptr) : mem[rd_ptr % 256];
            rd_ptr++;
            if (rst && n_reads == err_idx) begin
                fifo_error = 1'b1;
            end else begin
                e.data = fifo_rdata;
                e.last = ((exp_idx % BL) == (BL - 1));
                exp_q.push_back(e);
                exp_idx++;
            end
        end
        fifo_empty = gen_mode ? 1'b0 : (rd_ptr == wr_ptr);
    endtask

    task automatic do_reset();
        gen_mode = 1'b0;
        rst = 1'b0;
        en = 1'b0;
        m_ready = 1'b0;
        cycle();
        cycle();
        exp_q.delete();
        exp_idx = 0; n_reads = 0; n_beats = 0; err_idx = 0;
        first_rd = -1; first_vld = -1; first_beat = -1; last_beat = -1;
        wr_ptr = rd_ptr;
        fifo_empty = 1'b1;
    endtask

    task automatic preload(input int n, input int base);
        for (int k = 0; k < n; k++) begin
            mem[wr_ptr % 256] = DW'(base + k);
            wr_ptr++;
        end
        fifo_empty = (rd_ptr == wr_ptr);
    endtask

    initial begin
        bit done, stall_done;
        clk = 1'b0; rst = 1'b0; en = 1'b0; m_ready = 1'b0;
        fifo_error = 1'b0; fifo_rdata = '0; fifo_empty = 1'b1;
        checks = 0; errors = 0; n_reads = 0; n_beats = 0; exp_idx = 0; err_idx = 0; cyc = 0;
        first_rd = -1; first_vld = -1; first_beat = -1; last_beat = -1;
        wr_ptr = 0; rd_ptr = 0; gen_mode = 1'b0; prev_hold = 1'b0;
        prev_data = '0; prev_last = 1'b0;

        //             words stall drop err timing beats reads underrun
        vecs[0] = '{8, 0, 0, 0, 1'b1, 8, 8, 1'b0};  // plain streaming
        vecs[1] = '{8, 2, 0, 0, 1'b0, 8, 8, 1'b0};  // backpressure mid-stream
        vecs[2] = '{8, 0, 3, 0, 1'b0, 3, 3, 1'b0};  // en dropped after 3 reads
        vecs[3] = '{8, 0, 0, 2, 1'b0, 7, 8, 1'b1};  // error on 2nd capture

        // Reset held two cycles with 3 words waiting and the sink/enable active.
        preload(3, 8'hA0);
        en = 1'b1;
        m_ready = 1'b1;
        cycle();
        cycle();
        check("rst_read_en", 32'(fifo_read_en), 32'd0);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_data", 32'(m_data), 32'd0);
        check("rst_m_last", 32'(m_last), 32'd0);
        check("rst_beat_cnt", 32'(beat_cnt), 32'd0);
        check("rst_underrun", 32'(underrun), 32'd0);
        check("rst_state", 32'(state), 32'd0);

        for (int i = 0; i < 4; i++) begin
            do_reset();
            preload(vecs[i].n_words, 16 * i + 1);
            err_idx = vecs[i].err_word;
            rst = 1'b1; en = 1'b1; m_ready = 1'b1;
            done = 1'b0; stall_done = 1'b0;
            for (int t = 0; t < 300 && !done; t++) begin
                if (vecs[i].stall_at > 0 && !stall_done && n_beats >= vecs[i].stall_at) begin
                    stall_done = 1'b1;
                    m_ready = 1'b0;
                    repeat (5) cycle();
                    check("stall_state", 32'(state), 32'd2);
                    check("stall_read_en", 32'(fifo_read_en), 32'd0);
                    check("stall_reads", 32'(n_reads), 32'(n_beats + 2));
                    m_ready = 1'b1;
                end
                if (vecs[i].drop_after > 0 && n_reads >= vecs[i].drop_after) en = 1'b0;
                cycle();
                if (n_beats >= vecs[i].exp_beats && state == 2'd0 && exp_q.size() == 0) done = 1'b1;
            end
            check($sformatf("r%0d_done", i), 32'(done), 32'd1);
            repeat (3) cycle();
            check($sformatf("r%0d_beats", i), 32'(n_beats), 32'(vecs[i].exp_beats));
            check($sformatf("r%0d_reads", i), 32'(n_reads), 32'(vecs[i].exp_reads));
            check($sformatf("r%0d_beat_cnt", i), 32'(beat_cnt), 32'(vecs[i].exp_beats));
            check($sformatf("r%0d_underrun", i), 32'(underrun), 32'(vecs[i].exp_underrun));
            check($sformatf("r%0d_state", i), 32'(state), 32'd0);
            check($sformatf("r%0d_sb_empty", i), 32'(exp_q.size()), 32'd0);
            if (vecs[i].chk_timing) begin
                check("latency", 32'(first_vld - first_rd), 32'd2);
                check("contiguous", 32'(last_beat - first_beat), 32'(vecs[i].exp_beats - 1));
            end
        end

        // Reset in the middle of a stream: buffered and in-flight words vanish.
        do_reset();
        preload(8, 8'h50);
        rst = 1'b1; en = 1'b1; m_ready = 1'b1;
        repeat (4) cycle();
        rst = 1'b0;
        cycle();
        cycle();
        check("mid_rst_valid", 32'(m_valid), 32'd0);
        check("mid_rst_beat_cnt", 32'(beat_cnt), 32'd0);
        check("mid_rst_state", 32'(state), 32'd0);
        exp_q.delete();
        exp_idx = 0; n_beats = 0; n_reads = 0;
        rst = 1'b1; en = 1'b0;
        repeat (4) cycle();
        check("mid_rst_stale", 32'(n_beats), 32'd0);
        check("mid_rst_no_read", 32'(n_reads), 32'd0);

        // Counter wrap: 65537 beats from a never-empty FIFO.
        do_reset();
        gen_mode = 1'b1;
        fifo_empty = 1'b0;
        rst = 1'b1; en = 1'b1; m_ready = 1'b1;
        for (int t = 0; t < 66000 && n_reads < 65537; t++) cycle();
        en = 1'b0;
        for (int t = 0; t < 20 && !(state == 2'd0 && n_beats >= 65537); t++) cycle();
        check("wrap_reads", 32'(n_reads), 32'd65537);
        check("wrap_beats", 32'(n_beats), 32'd65537);
        check("wrap_beat_cnt", 32'(beat_cnt), 32'd1);
        check("wrap_state", 32'(state), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
